pool2_ctrl: RTL and testbench
=============================

// Module: pool2_ctrl
// PURPOSE
//  Consumer side of the f4 feature buffer that the conv-2 stage fills (10x10 map, addr = row*10+col).
//  After conv-2 signals completion, walks f4 in 2x2 windows, stride 2, and applies signed max-pooling.
//  Writes the 5x5 result into the f5 buffer, addr = row*5+col.
//  Contains the read-address generator, read-latency alignment, max datapath and write/done control.
// PARAMETERS
//  DW      16  f4/f5 data width, two's-complement signed
//  IN_DIM  10  f4 side length
//  OUT_DIM 5   f5 side length (= IN_DIM/2)
//  RD_LAT  2   f4 buffer read latency: cycles from f4_raddr to f4_rdata valid
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  pool2_start  in   1      start request, sampled only in IDLE (level or pulse)
//  f4_raddr     out  7      f4 read address, registered
//  f4_rdata     in   DW     f4 read data, valid RD_LAT cycles after f4_raddr
//  f5_waddr     out  5      f5 write address
//  f5_wdata     out  DW     f5 write data (window max)
//  f5_wr_en     out  1      f5 write strobe, 1 cycle per result
//  pool2_busy   out  1      high from the cycle after start is accepted through the done cycle
//  pool2_done   out  1      1-cycle pulse after the last f5 write
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, max register 0. Reset mid-run aborts at once; no further writes.
//  FSM (one-hot): IDLE -start-> RUN -last read issued-> DRAIN -pipe empty-> DONE -> IDLE.
//  Start while not IDLE is ignored.
//  Counters in RUN, 1 increment per cycle:
//   - cnt0: window col 0..1
//   - cnt1: window row 0..1
//   - cnt2: out col 0..4
//   - cnt3: out row 0..4
//   Each counter wraps to 0 and carries into the next. 100 reads total, no stalls.
//  Read address = (2*cnt3+cnt1)*IN_DIM + 2*cnt2 + cnt0, registered (1 cycle).
//  first/last tags (cnt0==0&&cnt1==0 / cnt0==1&&cnt1==1) and out addr cnt3*5+cnt2:
//   - delayed 1+RD_LAT cycles so they align with f4_rdata.
//  Aligned cycle: first -> max<=f4_rdata; else max<=(signed f4_rdata > max) ? f4_rdata : max.
//   - Equal values keep max.
//  Aligned last: next cycle f5_wr_en=1, f5_wdata=final max, f5_waddr=aligned out addr.
//   - Writes occur exactly every 4 cycles, 25 in total.
//  Timing, start high in cycle 0 (RD_LAT=2):
//   - RUN cycles 1..100; f4_raddr valid cycles 2..101
//   - first write cycle 8 (addr 0); last write cycle 104 (addr 24)
//   - pool2_done cycle 105; IDLE again in cycle 106
//   - general: first write = 6+RD_LAT, done = 103+RD_LAT
//  pool2_busy = RUN|DRAIN|DONE. f5_wr_en is 0 outside write cycles; f5_waddr/f5_wdata hold their last value.
//  Widths: address math in 7 bits, max 99; no overflow. Comparison is signed DW-bit.
// STRUCTURE
//  Shared package lenet_pkg:
//   - F4_DIM=10, F5_DIM=5, DATA_W=16, BUF_RD_LAT=2
//   - one-hot state localparams IDLE/RUN/DRAIN/DONE
//  Sub-module pipe_dly #(W,N): N-stage register delay line.
//   - Used for the tag/out-addr alignment; N=0 passes through.
//  Max datapath, counters and FSM stay in the top module.
// TESTING
//  1 f4[i]=i, start at cycle 0:
//    -> f5[r*5+c]=(2r+1)*10+2c+1 (f5[0]=11, f5[24]=99)
//    -> first write at cycle 8, last at cycle 104, done at cycle 105, exactly 25 writes
//  2 f4 all 0x8000 except one 0xFFFF per window, placed in a different window slot each time
//    -> every f5=0xFFFF (signed compare, position-independent)
//  3 f4 all 0x7FFF; then a window of equal negatives 0xFF00
//    -> f5 = 0x7FFF / 0xFF00, no corruption from the first-element load
//  4 pool2_start held high throughout
//    -> a run restarts only after IDLE (cycle 106); 2nd run is identical
//    -> pulse during busy: ignored
//  5 rst_n low at cycle 50
//    -> all outputs 0 next cycle, no writes after
//    -> fresh start reproduces scenario 1 exactly
//  6 Address trace check
//    -> f4_raddr sequence begins 0,1,10,11,2,3,12,13; ends 88,89,98,99

Source files
------------

// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
// Shared constants and types for the LeNet feature-map buffers and the
// stages that move data between them.
//   F4_DIM / F5_DIM : side lengths of the conv-2 output map and the pooled map
//   DATA_W          : feature data width, two's-complement signed
//   BUF_RD_LAT      : feature-buffer read latency in cycles
//   ST_*            : one-hot encodings of the pooling controller states
// -----------------------------------------------------------------------------
package lenet_pkg;

   localparam int F4_DIM     = 10;
   localparam int F5_DIM     = 5;
   localparam int DATA_W     = 16;
   localparam int BUF_RD_LAT = 2;

   localparam logic [3:0] ST_IDLE  = 4'b0001;
   localparam logic [3:0] ST_RUN   = 4'b0010;
   localparam logic [3:0] ST_DRAIN = 4'b0100;
   localparam logic [3:0] ST_DONE  = 4'b1000;

   typedef enum logic [3:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN,
      DONE  = ST_DONE
   } pool2_state_e;

   // Per-read side information that travels down the alignment pipe so it
   // arrives together with the corresponding f4 read data.
   typedef struct packed {
      logic       valid;
      logic       first;
      logic       last;
      logic       final_rd;
      logic [4:0] out_addr;
   } pool2_tag_t;

endpackage

// File: rtl/pipe_dly.sv
// -----------------------------------------------------------------------------
// pipe_dly
// N-stage register delay line with asynchronous active-low reset.
// N = 0 degenerates to a straight wire.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset, clears every stage
//   d      in  W  data in
//   q      out W  data out, N cycles after d
// -----------------------------------------------------------------------------
module pipe_dly #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (N == 0) begin : g_wire
      assign q = d;
   end else begin : g_dly
      logic [W-1:0] stage_q [N];
      logic [W-1:0] stage_d [N];

      always_comb begin
         stage_d[0] = d;
         for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
               stage_q[i] <= '0;
            end
         end else begin
            stage_q <= stage_d;
         end
      end

      assign q = stage_q[N-1];
   end

endmodule

// File: rtl/pool2_ctrl.sv
// -----------------------------------------------------------------------------
// pool2_ctrl
// Walks the 10x10 f4 map in 2x2 windows (stride 2), computes the signed
// maximum of each window and writes the 5x5 result to the f5 buffer.
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   pool2_start  in   1   start request, only looked at in IDLE
//   f4_raddr     out  7   f4 read address (registered)
//   f4_rdata     in   DW  f4 read data, RD_LAT cycles after f4_raddr
//   f5_waddr     out  5   f5 write address
//   f5_wdata     out  DW  f5 write data (window max)
//   f5_wr_en     out  1   f5 write strobe, one cycle per result
//   pool2_busy   out  1   high in RUN, DRAIN and DONE
//   pool2_done   out  1   one-cycle pulse after the last f5 write
// -----------------------------------------------------------------------------
module pool2_ctrl
   import lenet_pkg::*;
#(
   parameter int DW      = DATA_W,
   parameter int IN_DIM  = F4_DIM,
   parameter int OUT_DIM = F5_DIM,
   parameter int RD_LAT  = BUF_RD_LAT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pool2_start,
   output logic [6:0]    f4_raddr,
   input  logic [DW-1:0] f4_rdata,
   output logic [4:0]    f5_waddr,
   output logic [DW-1:0] f5_wdata,
   output logic          f5_wr_en,
   output logic          pool2_busy,
   output logic          pool2_done
);

   localparam logic [2:0] OUT_LAST = 3'(OUT_DIM - 1);

   pool2_state_e state_q, state_d;

   logic          cnt0_q, cnt0_d;
   logic          cnt1_q, cnt1_d;
   logic [2:0]    cnt2_q, cnt2_d;
   logic [2:0]    cnt3_q, cnt3_d;
   logic [6:0]    f4_raddr_q, f4_raddr_d;
   logic [DW-1:0] max_q, max_d;
   logic [4:0]    f5_waddr_q, f5_waddr_d;
   logic [DW-1:0] f5_wdata_q, f5_wdata_d;
   logic          f5_wr_en_q, f5_wr_en_d;
   logic          final_wr_q, final_wr_d;

   logic       in_run;
   logic       last_read;
   pool2_tag_t tag_issue;
   pool2_tag_t tag_align;

   assign in_run    = (state_q == RUN);
   assign last_read = in_run && cnt0_q && cnt1_q &&
                      (cnt2_q == OUT_LAST) && (cnt3_q == OUT_LAST);

   // Control FSM. DRAIN waits for the write of the very last window, which is
   // identified by the final-read tag rather than by counting cycles, so the
   // exit stays correct for any read latency.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pool2_start) state_d = RUN;
         RUN:     if (last_read)   state_d = DRAIN;
         DRAIN:   if (final_wr_q)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Window walk: cnt0 is the innermost (window column), cnt3 the outermost
   // (output row). Counters are forced to 0 outside RUN so a new run always
   // starts at the top-left window.
   always_comb begin
      cnt0_d = 1'b0;
      cnt1_d = 1'b0;
      cnt2_d = '0;
      cnt3_d = '0;
      if (in_run) begin
         cnt0_d = ~cnt0_q;
         cnt1_d = cnt1_q;
         cnt2_d = cnt2_q;
         cnt3_d = cnt3_q;
         if (cnt0_q) begin
            cnt1_d = ~cnt1_q;
            if (cnt1_q) begin
               if (cnt2_q == OUT_LAST) begin
                  cnt2_d = '0;
                  cnt3_d = (cnt3_q == OUT_LAST) ? 3'd0 : cnt3_q + 3'd1;
               end else begin
                  cnt2_d = cnt2_q + 3'd1;
               end
            end
         end
      end
   end

   // Read address and the tag that will meet the returned data. The
   // concatenations {cnt3,cnt1} and {cnt2,cnt0} are the f4 row and column.
   always_comb begin
      f4_raddr_d = f4_raddr_q;
      if (in_run) begin
         f4_raddr_d = 7'({cnt3_q, cnt1_q}) * 7'(IN_DIM) + 7'({cnt2_q, cnt0_q});
      end
      tag_issue.valid    = in_run;
      tag_issue.first    = in_run && !cnt0_q && !cnt1_q;
      tag_issue.last     = in_run && cnt0_q && cnt1_q;
      tag_issue.final_rd = last_read;
      tag_issue.out_addr = 5'(cnt3_q) * 5'(OUT_DIM) + 5'(cnt2_q);
   end

   // One cycle for the registered address plus the buffer read latency.
   pipe_dly #(
      .W ($bits(pool2_tag_t)),
      .N (1 + RD_LAT)
   ) u_tag_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tag_issue),
      .q     (tag_align)
   );

   // Max datapath and write generation. The first element of a window loads
   // the register unconditionally so the previous window's max never leaks
   // in; ties keep the stored value. The write carries max_d so the result
   // of the last element is included.
   always_comb begin
      max_d      = max_q;
      f5_wr_en_d = 1'b0;
      f5_waddr_d = f5_waddr_q;
      f5_wdata_d = f5_wdata_q;
      final_wr_d = 1'b0;
      if (tag_align.valid) begin
         if (tag_align.first) begin
            max_d = f4_rdata;
         end else if ($signed(f4_rdata) > $signed(max_q)) begin
            max_d = f4_rdata;
         end
         if (tag_align.last) begin
            f5_wr_en_d = 1'b1;
            f5_waddr_d = tag_align.out_addr;
            f5_wdata_d = max_d;
            final_wr_d = tag_align.final_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt0_q     <= 1'b0;
         cnt1_q     <= 1'b0;
         cnt2_q     <= '0;
         cnt3_q     <= '0;
         f4_raddr_q <= '0;
         max_q      <= '0;
         f5_waddr_q <= '0;
         f5_wdata_q <= '0;
         f5_wr_en_q <= 1'b0;
         final_wr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
         cnt2_q     <= cnt2_d;
         cnt3_q     <= cnt3_d;
         f4_raddr_q <= f4_raddr_d;
         max_q      <= max_d;
         f5_waddr_q <= f5_waddr_d;
         f5_wdata_q <= f5_wdata_d;
         f5_wr_en_q <= f5_wr_en_d;
         final_wr_q <= final_wr_d;
      end
   end

   assign f4_raddr   = f4_raddr_q;
   assign f5_waddr   = f5_waddr_q;
   assign f5_wdata   = f5_wdata_q;
   assign f5_wr_en   = f5_wr_en_q;
   assign pool2_busy = (state_q == RUN) || (state_q == DRAIN) || (state_q == DONE);
   assign pool2_done = (state_q == DONE);

endmodule

// File: tb/tb_pool2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pool2_ctrl
// Self-checking bench for pool2_ctrl: models the f4 buffer (2-cycle read
// latency), predicts every f5 write from the f4 contents into a queue and
// compares writes as they appear, plus timing/address tables per run.
// -----------------------------------------------------------------------------
module tb_pool2_ctrl;
   import lenet_pkg::*;

   localparam int DW    = DATA_W;
   localparam int LOG_N = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pool2_start = 1'b0;
   logic [6:0]    f4_raddr;
   logic [DW-1:0] f4_rdata = '0;
   logic [4:0]    f5_waddr;
   logic [DW-1:0] f5_wdata;
   logic          f5_wr_en;
   logic          pool2_busy;
   logic          pool2_done;

   pool2_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pool2_start (pool2_start),
      .f4_raddr    (f4_raddr),
      .f4_rdata    (f4_rdata),
      .f5_waddr    (f5_waddr),
      .f5_wdata    (f5_wdata),
      .f5_wr_en    (f5_wr_en),
      .pool2_busy  (pool2_busy),
      .pool2_done  (pool2_done)
   );

   always #5 clk = ~clk;

   // f4 buffer model: address registered at the edge, data two cycles later.
   logic [DW-1:0] f4_mem [100];
   logic [DW-1:0] rd_p1 = '0;
   always @(posedge clk) begin
      rd_p1    <= (f4_raddr < 7'd100) ? f4_mem[f4_raddr] : '0;
      f4_rdata <= rd_p1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [4:0]    addr;
      logic [DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int   cyc;
      logic busy;
      logic done;
      logic wr_en;
      int   waddr;
   } tvec_t;
   tvec_t tv[14];

   int n_vec = 0;
   int n_err = 0;
   int t0 = 0;
   int mon_rel;
   int n_writes = 0;
   int wr_rel[$];
   exp_t got;

   logic       log_busy  [LOG_N];
   logic       log_done  [LOG_N];
   logic       log_wr    [LOG_N];
   logic [4:0] log_waddr [LOG_N];
   logic [6:0] log_raddr [LOG_N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard side: log per-cycle outputs and compare every f5 write.
   always @(negedge clk) begin
      mon_rel = cyc - t0;
      if (mon_rel >= 0 && mon_rel < LOG_N) begin
         log_busy[mon_rel]  = pool2_busy;
         log_done[mon_rel]  = pool2_done;
         log_wr[mon_rel]    = f5_wr_en;
         log_waddr[mon_rel] = f5_waddr;
         log_raddr[mon_rel] = f4_raddr;
      end
      if (f5_wr_en === 1'b1) begin
         n_writes++;
         wr_rel.push_back(mon_rel);
         if (exp_q.size() == 0) begin
            check($sformatf("unexpected_write@%0d", mon_rel), 32'(1), 32'(0));
         end else begin
            got = exp_q.pop_front();
            check($sformatf("f5_waddr@%0d", mon_rel), 32'(f5_waddr), 32'(got.addr));
            check($sformatf("f5_wdata@%0d", mon_rel), 32'(f5_wdata), 32'(got.data));
         end
      end
   end

   // Reference model: signed max over each 2x2 window of the current f4 image.
   task automatic push_expected();
      logic signed [DW-1:0] m, v;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            m = f4_mem[(2*r)*10 + 2*c];
            for (int dr = 0; dr < 2; dr++) begin
               for (int dc = 0; dc < 2; dc++) begin
                  v = f4_mem[(2*r+dr)*10 + 2*c + dc];
                  if (v > m) m = v;
               end
            end
            exp_q.push_back('{addr: 5'(r*5 + c), data: m});
         end
      end
   endtask

   // Starts a run in the cycle after the next edge; that cycle is cycle 0.
   task automatic start_run(input bit hold);
      @(posedge clk);
      #1;
      t0 = cyc;
      for (int i = 0; i < LOG_N; i++) begin
         log_busy[i] = 1'b0; log_done[i] = 1'b0; log_wr[i] = 1'b0;
         log_waddr[i] = '0;  log_raddr[i] = '0;
      end
      n_writes = 0;
      wr_rel.delete();
      push_expected();
      pool2_start = 1'b1;
      if (!hold) begin
         @(posedge clk);
         #1;
         pool2_start = 1'b0;
      end
   endtask

   task automatic applyStimulus_ramp();
      for (int i = 0; i < 100; i++) f4_mem[i] = 16'(i);
   endtask

   task automatic checkOutput_run(input string tag);
      check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'(0));
      check({tag, "_write_count"}, 32'(n_writes), 32'(25));
   endtask

   // Full timing and address-trace check of a single pulse-started ramp run.
   task automatic checkOutput_ramp(input string tag);
      int c, a;
      checkOutput_run(tag);
      if (wr_rel.size() == 25) begin
         check({tag, "_first_write_cycle"}, 32'(wr_rel[0]), 32'(8));
         check({tag, "_last_write_cycle"}, 32'(wr_rel[24]), 32'(104));
      end
      for (int i = 0; i < 14; i++) begin
         c = tv[i].cyc;
         check($sformatf("%s_busy@%0d", tag, c), 32'(log_busy[c]), 32'(tv[i].busy));
         check($sformatf("%s_done@%0d", tag, c), 32'(log_done[c]), 32'(tv[i].done));
         check($sformatf("%s_wr_en@%0d", tag, c), 32'(log_wr[c]), 32'(tv[i].wr_en));
         if (tv[i].waddr >= 0)
            check($sformatf("%s_waddr@%0d", tag, c), 32'(log_waddr[c]), 32'(tv[i].waddr));
      end
      for (int i = 0; i < 100; i++) begin
         a = ((2*(i/20) + (i/2)%2) * 10) + 2*((i/4)%5) + (i%2);
         check($sformatf("%s_raddr@%0d", tag, 2+i), 32'(log_raddr[2+i]), 32'(a));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_f4_raddr"}, 32'(f4_raddr), 32'(0));
      check({tag, "_f5_waddr"}, 32'(f5_waddr), 32'(0));
      check({tag, "_f5_wdata"}, 32'(f5_wdata), 32'(0));
      check({tag, "_f5_wr_en"}, 32'(f5_wr_en), 32'(0));
      check({tag, "_busy"}, 32'(pool2_busy), 32'(0));
      check({tag, "_done"}, 32'(pool2_done), 32'(0));
   endtask

   initial begin
      tv[0]  = '{0,   1'b0, 1'b0, 1'b0, -1};
      tv[1]  = '{1,   1'b1, 1'b0, 1'b0, -1};
      tv[2]  = '{2,   1'b1, 1'b0, 1'b0, -1};
      tv[3]  = '{7,   1'b1, 1'b0, 1'b0, -1};
      tv[4]  = '{8,   1'b1, 1'b0, 1'b1, 0};
      tv[5]  = '{9,   1'b1, 1'b0, 1'b0, -1};
      tv[6]  = '{12,  1'b1, 1'b0, 1'b1, 1};
      tv[7]  = '{100, 1'b1, 1'b0, 1'b1, 23};
      tv[8]  = '{101, 1'b1, 1'b0, 1'b0, -1};
      tv[9]  = '{103, 1'b1, 1'b0, 1'b0, -1};
      tv[10] = '{104, 1'b1, 1'b0, 1'b1, 24};
      tv[11] = '{105, 1'b1, 1'b1, 1'b0, -1};
      tv[12] = '{106, 1'b0, 1'b0, 1'b0, -1};
      tv[13] = '{107, 1'b0, 1'b0, 1'b0, -1};

      for (int i = 0; i < 100; i++) f4_mem[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // 1: ramp image, timing and address trace
      $display("[TB] ramp run");
      applyStimulus_ramp();
      start_run(1'b0);
      repeat (115) @(posedge clk);
      checkOutput_ramp("ramp");

      // 2: one 0xFFFF per window over 0x8000, slot rotates per window
      $display("[TB] signed max, rotating slot");
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            for (int s = 0; s < 4; s++)
               f4_mem[(2*r + s/2)*10 + 2*c + s%2] = (s == (r*5 + c) % 4) ? 16'hFFFF : 16'h8000;
      start_run(1'b0);
      repeat (115) @(posedge clk);
      checkOutput_run("slot");

      // 3: all 0x7FFF, then the same with windows of equal negatives
      $display("[TB] first-element load");
      for (int i = 0; i < 100; i++) f4_mem[i] = 16'h7FFF;
      start_run(1'b0);
      repeat (115) @(posedge clk);
      checkOutput_run("pos");
      for (int s = 0; s < 4; s++) begin
         f4_mem[(4 + s/2)*10 + 4 + s%2] = 16'hFF00;
         f4_mem[(8 + s/2)*10 + 8 + s%2] = 16'hFF00;
      end
      start_run(1'b0);
      repeat (115) @(posedge clk);
      checkOutput_run("neg");

      // 4a: start held high, back-to-back runs
      $display("[TB] start held high");
      applyStimulus_ramp();
      start_run(1'b1);
      push_expected();
      repeat (110) @(posedge clk);
      #1;
      pool2_start = 1'b0;
      repeat (120) @(posedge clk);
      check("held_sb_drained", 32'(exp_q.size()), 32'(0));
      check("held_write_count", 32'(n_writes), 32'(50));
      check("held_busy@105", 32'(log_busy[105]), 32'(1));
      check("held_busy@106", 32'(log_busy[106]), 32'(0));
      check("held_busy@107", 32'(log_busy[107]), 32'(1));
      check("held_done@211", 32'(log_done[211]), 32'(1));
      if (wr_rel.size() == 50) begin
         check("held_run2_first_write", 32'(wr_rel[25]), 32'(114));
         check("held_run2_last_write", 32'(wr_rel[49]), 32'(210));
      end
      for (int i = 0; i < 8; i++)
         check($sformatf("held_run2_raddr@%0d", 108+i), 32'(log_raddr[108+i]), 32'(log_raddr[2+i]));

      // 4b: start pulse while busy is ignored
      $display("[TB] start pulse during busy");
      for (int i = 0; i < 100; i++) f4_mem[i] = 16'($urandom);
      start_run(1'b0);
      repeat (49) @(posedge clk);
      #1;
      pool2_start = 1'b1;
      @(posedge clk);
      #1;
      pool2_start = 1'b0;
      repeat (89) @(posedge clk);
      checkOutput_run("pulse");
      check("pulse_done@105", 32'(log_done[105]), 32'(1));
      check("pulse_busy@106", 32'(log_busy[106]), 32'(0));
      check("pulse_busy@120", 32'(log_busy[120]), 32'(0));

      // 5: reset mid-run, then a fresh ramp run
      $display("[TB] reset mid-run");
      applyStimulus_ramp();
      start_run(1'b0);
      repeat (49) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (150) @(posedge clk);
      check("midreset_write_count", 32'(n_writes), 32'(11));
      if (wr_rel.size() > 0)
         check("midreset_last_write", 32'(wr_rel[wr_rel.size()-1]), 32'(48));
      start_run(1'b0);
      repeat (115) @(posedge clk);
      checkOutput_ramp("rerun");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
